// File: rtl/railway_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : railway_pkg
//  Description : Shared types and constants for the crossing speed tracker:
//                per-channel measurement states, divider engine states and
//                the travel-direction encoding reported with each record.
//  Revision    : 1.0  initial release
// ============================================================================
package railway_pkg;

    // Per-channel measurement state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TIMING  = 2'd1,
        PENDING = 2'd2
    } chan_state_t;

    // Shared divider engine state
    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_DIV  = 2'd1,
        D_DONE = 2'd2
    } div_state_t;

    // Direction of travel: opened by A and closed by B, or the reverse
    localparam logic DIR_AB = 1'b0;
    localparam logic DIR_BA = 1'b1;

endpackage
`default_nettype wire

// File: rtl/speed_divider.sv
`default_nettype none
// ============================================================================
//  Module      : speed_divider
//  Description : Sequential restoring divider, one quotient bit per cycle.
//                A start pulse loads the operands; NUM_W cycles later the
//                quotient register holds dividend/divisor.
//  Ports       : clk, rst_n       clock, asynchronous active-low reset
//                start            load operands and begin a division
//                dividend/divisor NUM_W-bit operands (divisor must be >= 1)
//                done             high in the cycle that computes the final
//                                 quotient bit; quotient is complete from the
//                                 next cycle onward
//                quotient         quotient register
//  Revision    : 1.0  initial release
// ============================================================================
module speed_divider #(
    parameter int NUM_W = 32,
    localparam int STEP_W = $clog2(NUM_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [NUM_W-1:0] divisor,
    output logic             done,
    output logic [NUM_W-1:0] quotient
);

    logic [NUM_W-1:0]  quo_q, quo_d;
    logic [NUM_W-1:0]  rem_q, rem_d;
    logic [NUM_W-1:0]  dvs_q, dvs_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [NUM_W:0]    trial;
    logic [NUM_W:0]    diff;

    // The dividend is shifted out of the top of the quotient register into
    // the partial remainder while quotient bits are shifted in at the bottom.
    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        step_d = step_q;
        trial  = {rem_q, quo_q[NUM_W-1]};
        diff   = trial - {1'b0, dvs_q};
        if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
            step_d = STEP_W'(NUM_W);
        end else if (step_q != '0) begin
            // Borrow out of diff means the trial remainder is below divisor
            if (!diff[NUM_W]) begin
                rem_d = diff[NUM_W-1:0];
                quo_d = {quo_q[NUM_W-2:0], 1'b1};
            end else begin
                rem_d = trial[NUM_W-1:0];
                quo_d = {quo_q[NUM_W-2:0], 1'b0};
            end
            step_d = step_q - STEP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            step_q <= '0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            step_q <= step_d;
        end
    end

    assign done     = (step_q == STEP_W'(1));
    assign quotient = quo_q;

endmodule
`default_nettype wire

// File: rtl/train_speed_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : train_speed_tracker
//  Description : Multi-channel direction-aware train speed measurement.
//                Each channel times the interval between rising edges of its
//                two track sensors; finished measurements are arbitrated
//                round-robin onto one shared divider and reported as records
//                over a valid/ready stream.
//  Ports       : clk, rst_n        clock, asynchronous active-low reset
//                sens_a, sens_b    pre-synchronised sensor levels per channel
//                out_valid/ready   record handshake
//                out_chan          channel of the record
//                out_speed         DIST_CONST/elapsed, saturated; 0 on timeout
//                out_dir           0 = A->B, 1 = B->A
//                out_timeout       record reports an abandoned measurement
//                chan_busy         per-channel "not IDLE" flags
//  Revision    : 1.0  initial release
// ============================================================================
module train_speed_tracker
    import railway_pkg::*;
#(
    parameter int               NUM_CROSSINGS = 4,
    parameter int               CNT_W         = 24,
    parameter int               NUM_W         = 32,
    parameter int               SPEED_W       = 16,
    parameter logic [NUM_W-1:0] DIST_CONST    = NUM_W'(1000000),
    parameter int               TIMEOUT_CYC   = 2**24 - 1,
    localparam int              CH_W          = (NUM_CROSSINGS > 1) ? $clog2(NUM_CROSSINGS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CROSSINGS-1:0] sens_a,
    input  logic [NUM_CROSSINGS-1:0] sens_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_chan,
    output logic [SPEED_W-1:0]       out_speed,
    output logic                     out_dir,
    output logic                     out_timeout,
    output logic [NUM_CROSSINGS-1:0] chan_busy
);

    logic [NUM_CROSSINGS-1:0] grant;
    logic [NUM_CROSSINGS-1:0] pend;
    logic [NUM_CROSSINGS-1:0] dir_vec;
    logic [NUM_CROSSINGS-1:0] tmo_vec;
    logic [CNT_W-1:0]         elapsed_arr [NUM_CROSSINGS];

    // ------------------------------------------------------------------
    // Per-channel measurement FSMs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CROSSINGS; i++) begin : g_chan
        chan_state_t      state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             dir_q, dir_d;
        logic             tmo_q, tmo_d;
        logic             a_q, b_q;
        logic             rise_a, rise_b, close_edge;

        always_comb begin
            rise_a     = sens_a[i] & ~a_q;
            rise_b     = sens_b[i] & ~b_q;
            close_edge = (dir_q == DIR_BA) ? rise_a : rise_b;
            state_d    = state_q;
            cnt_d      = cnt_q;
            dir_d      = dir_q;
            tmo_d      = tmo_q;
            unique case (state_q)
                IDLE: begin
                    // Simultaneous edges give no direction, so they are dropped
                    if (rise_a ^ rise_b) begin
                        state_d = TIMING;
                        dir_d   = rise_b ? DIR_BA : DIR_AB;
                        cnt_d   = CNT_W'(1);
                        tmo_d   = 1'b0;
                    end
                end
                TIMING: begin
                    // The counter freezes on exit and doubles as elapsed time
                    if (close_edge) begin
                        state_d = PENDING;
                        tmo_d   = 1'b0;
                    end else if (cnt_q >= CNT_W'(TIMEOUT_CYC)) begin
                        state_d = PENDING;
                        tmo_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PENDING: begin
                    if (grant[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                dir_q   <= DIR_AB;
                tmo_q   <= 1'b0;
                a_q     <= 1'b0;
                b_q     <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                dir_q   <= dir_d;
                tmo_q   <= tmo_d;
                a_q     <= sens_a[i];
                b_q     <= sens_b[i];
            end
        end

        assign pend[i]        = (state_q == PENDING);
        assign chan_busy[i]   = (state_q != IDLE);
        assign dir_vec[i]     = dir_q;
        assign tmo_vec[i]     = tmo_q;
        assign elapsed_arr[i] = cnt_q;
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter, only active while the engine is idle
    // ------------------------------------------------------------------
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] grant_idx;
    logic [CH_W:0]   scan_idx;
    logic            grant_vld;
    div_state_t      eng_q, eng_d;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        grant     = '0;
        if (eng_q == D_IDLE) begin
            // Scan from the far end back to rr_ptr so the nearest hit wins
            for (int k = NUM_CROSSINGS - 1; k >= 0; k--) begin
                scan_idx = {1'b0, rr_ptr_q} + (CH_W + 1)'(k);
                if (scan_idx >= (CH_W + 1)'(NUM_CROSSINGS)) begin
                    scan_idx = scan_idx - (CH_W + 1)'(NUM_CROSSINGS);
                end
                if (pend[scan_idx[CH_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx[CH_W-1:0];
                end
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == CH_W'(NUM_CROSSINGS - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Divider engine and output register
    // ------------------------------------------------------------------
    logic               div_start, div_done;
    logic [NUM_W-1:0]   quotient;
    logic [SPEED_W-1:0] speed_sat;
    logic [CH_W-1:0]    rec_chan_q, rec_chan_d;
    logic               rec_dir_q, rec_dir_d;
    logic               rec_tmo_q, rec_tmo_d;
    logic               out_valid_q, out_valid_d;
    logic [CH_W-1:0]    out_chan_q, out_chan_d;
    logic [SPEED_W-1:0] out_speed_q, out_speed_d;
    logic               out_dir_q, out_dir_d;
    logic               out_tmo_q, out_tmo_d;

    assign div_start = grant_vld & ~tmo_vec[grant_idx];

    speed_divider #(
        .NUM_W (NUM_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (DIST_CONST),
        .divisor  (NUM_W'(elapsed_arr[grant_idx])),
        .done     (div_done),
        .quotient (quotient)
    );

    always_comb begin
        speed_sat = (quotient > NUM_W'({SPEED_W{1'b1}})) ? {SPEED_W{1'b1}}
                                                          : quotient[SPEED_W-1:0];
        eng_d       = eng_q;
        rec_chan_d  = rec_chan_q;
        rec_dir_d   = rec_dir_q;
        rec_tmo_d   = rec_tmo_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_chan_d  = out_chan_q;
        out_speed_d = out_speed_q;
        out_dir_d   = out_dir_q;
        out_tmo_d   = out_tmo_q;
        unique case (eng_q)
            D_IDLE: begin
                if (grant_vld) begin
                    rec_chan_d = grant_idx;
                    rec_dir_d  = dir_vec[grant_idx];
                    rec_tmo_d  = tmo_vec[grant_idx];
                    eng_d      = tmo_vec[grant_idx] ? D_DONE : D_DIV;
                end
            end
            D_DIV: begin
                if (div_done) begin
                    eng_d = D_DONE;
                end
            end
            D_DONE: begin
                // Load only into an empty slot or one being emptied this cycle
                if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b1;
                    out_chan_d  = rec_chan_q;
                    out_speed_d = rec_tmo_q ? '0 : speed_sat;
                    out_dir_d   = rec_dir_q;
                    out_tmo_d   = rec_tmo_q;
                    eng_d       = D_IDLE;
                end
            end
            default: eng_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            eng_q       <= D_IDLE;
            rec_chan_q  <= '0;
            rec_dir_q   <= DIR_AB;
            rec_tmo_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_speed_q <= '0;
            out_dir_q   <= DIR_AB;
            out_tmo_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            eng_q       <= eng_d;
            rec_chan_q  <= rec_chan_d;
            rec_dir_q   <= rec_dir_d;
            rec_tmo_q   <= rec_tmo_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            out_speed_q <= out_speed_d;
            out_dir_q   <= out_dir_d;
            out_tmo_q   <= out_tmo_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_chan    = out_chan_q;
    assign out_speed   = out_speed_q;
    assign out_dir     = out_dir_q;
    assign out_timeout = out_tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_train_speed_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_train_speed_tracker
//  Description : Directed self-checking bench for train_speed_tracker with a
//                record scoreboard fed at stimulus time and drained by an
//                output monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_train_speed_tracker;

    localparam int N       = 4;
    localparam int NUM_W   = 32;
    localparam int SPEED_W = 16;
    localparam int DIST    = 1000000;
    localparam int TMO     = 5000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] sens_a, sens_b;
    logic         out_valid, out_ready;
    logic [1:0]   out_chan;
    logic [15:0]  out_speed;
    logic         out_dir, out_timeout;
    logic [N-1:0] chan_busy;

    train_speed_tracker #(
        .NUM_CROSSINGS (N),
        .CNT_W         (24),
        .NUM_W         (NUM_W),
        .SPEED_W       (SPEED_W),
        .DIST_CONST    (32'(DIST)),
        .TIMEOUT_CYC   (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sens_a      (sens_a),
        .sens_b      (sens_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_chan    (out_chan),
        .out_speed   (out_speed),
        .out_dir     (out_dir),
        .out_timeout (out_timeout),
        .chan_busy   (chan_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int   chan;
        int   speed;
        logic dir;
        logic tmo;
    } rec_t;
    rec_t sb[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic rec_t mk(int ch, int el, logic dir, logic tmo);
        rec_t r;
        int   q;
        q       = DIST / el;
        r.chan  = ch;
        r.speed = tmo ? 0 : ((q > 65535) ? 65535 : q);
        r.dir   = dir;
        r.tmo   = tmo;
        return r;
    endfunction

    // Output monitor: every accepted record is compared with the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_record", {31'b0, out_valid}, 32'd0);
            end else begin
                rec_t e;
                e = sb.pop_front();
                chk("rec_chan",    {30'b0, out_chan},    32'(e.chan));
                chk("rec_speed",   {16'b0, out_speed},   32'(e.speed));
                chk("rec_dir",     {31'b0, out_dir},     {31'b0, e.dir});
                chk("rec_timeout", {31'b0, out_timeout}, {31'b0, e.tmo});
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Opening edge, then closing edge el cycles later; dir 0 opens on A
    task automatic passage(int ch, logic dir, int el);
        if (dir == 1'b0) sens_a[ch] = 1'b1; else sens_b[ch] = 1'b1;
        tick(1);
        sens_a[ch] = 1'b0;
        sens_b[ch] = 1'b0;
        tick(el - 1);
        if (dir == 1'b0) sens_b[ch] = 1'b1; else sens_a[ch] = 1'b1;
        tick(1);
        sens_a[ch] = 1'b0;
        sens_b[ch] = 1'b0;
    endtask

    task automatic wait_busy_fall(int ch, int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!chan_busy[ch]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("busy_fall_bound", {31'b0, chan_busy[ch]}, 32'd0);
    endtask

    task automatic wait_valid(int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("valid_bound", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic drain(int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_bound", 32'(sb.size()), 32'd0);
    endtask

    int   t0, t1;
    bit   stable;
    logic [1:0]  snap_chan;
    logic [15:0] snap_speed;
    logic        snap_dir, snap_tmo;

    initial begin
        rst_n     = 1'b0;
        sens_a    = '0;
        sens_b    = '0;
        out_ready = 1'b1;

        // Reset values
        tick(3);
        @(negedge clk);
        chk("rst_valid",   {31'b0, out_valid},   32'd0);
        chk("rst_chan",    {30'b0, out_chan},    32'd0);
        chk("rst_speed",   {16'b0, out_speed},   32'd0);
        chk("rst_dir",     {31'b0, out_dir},     32'd0);
        chk("rst_timeout", {31'b0, out_timeout}, 32'd0);
        chk("rst_busy",    {28'b0, chan_busy},   32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(100);

        // Single A->B on ch0, interval 1000
        sb.push_back(mk(0, 1000, 1'b0, 1'b0));
        passage(0, 1'b0, 1000);
        wait_busy_fall(0, 100, t0);
        wait_valid(100, t1);
        chk("div_latency", 32'(t1 - t0), 32'(NUM_W + 1));
        drain(200);

        // B->A on ch2, interval 10 saturates
        sb.push_back(mk(2, 10, 1'b1, 1'b0));
        passage(2, 1'b1, 10);
        drain(200);

        // Timeout on ch1
        sb.push_back(mk(1, 1, 1'b0, 1'b1));
        sens_a[1] = 1'b1;
        tick(1);
        sens_a[1] = 1'b0;
        tick(4000);
        @(negedge clk);
        chk("tmo_busy_open", {31'b0, chan_busy[1]}, 32'd1);
        wait_busy_fall(1, 2000, t0);
        wait_valid(50, t1);
        chk("tmo_latency", 32'(t1 - t0), 32'd1);
        drain(200);

        // Contention: rr_ptr is now 2, ch1 and ch3 close together -> ch3 first
        sb.push_back(mk(3, 500, 1'b1, 1'b0));
        sb.push_back(mk(1, 400, 1'b0, 1'b0));
        sens_b[3] = 1'b1;
        tick(1);
        sens_b[3] = 1'b0;
        tick(99);
        sens_a[1] = 1'b1;
        tick(1);
        sens_a[1] = 1'b0;
        tick(399);
        sens_b[1] = 1'b1;
        sens_a[3] = 1'b1;
        tick(1);
        sens_b[1] = 1'b0;
        sens_a[3] = 1'b0;
        drain(300);

        // Backpressure with three channels completing
        out_ready = 1'b0;
        sb.push_back(mk(0, 100, 1'b0, 1'b0));
        sb.push_back(mk(1, 200, 1'b1, 1'b0));
        sb.push_back(mk(2, 400, 1'b0, 1'b0));
        sens_a[0] = 1'b1;
        sens_b[1] = 1'b1;
        sens_a[2] = 1'b1;
        tick(1);
        sens_a = '0;
        sens_b = '0;
        tick(99);
        sens_b[0] = 1'b1;
        tick(1);
        sens_b[0] = 1'b0;
        tick(99);
        sens_a[1] = 1'b1;
        tick(1);
        sens_a[1] = 1'b0;
        tick(199);
        sens_b[2] = 1'b1;
        tick(1);
        sens_b[2] = 1'b0;
        @(negedge clk);
        snap_chan  = out_chan;
        snap_speed = out_speed;
        snap_dir   = out_dir;
        snap_tmo   = out_timeout;
        stable     = out_valid;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!out_valid || out_chan !== snap_chan || out_speed !== snap_speed ||
                out_dir !== snap_dir || out_timeout !== snap_tmo) stable = 1'b0;
        end
        chk("bp_stable", {31'b0, stable},       32'd1);
        chk("bp_chan",   {30'b0, out_chan},     32'd0);
        chk("bp_speed",  {16'b0, out_speed},    32'd10000);
        chk("bp_busy1",  {31'b0, chan_busy[1]}, 32'd0);
        chk("bp_busy2",  {31'b0, chan_busy[2]}, 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain(400);

        // Reset during a division with an undelivered record held
        out_ready = 1'b0;
        passage(3, 1'b0, 20);
        wait_valid(100, t1);
        passage(0, 1'b0, 50);
        wait_busy_fall(0, 50, t0);
        tick(5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",   {31'b0, out_valid},   32'd0);
        chk("mid_rst_chan",    {30'b0, out_chan},    32'd0);
        chk("mid_rst_speed",   {16'b0, out_speed},   32'd0);
        chk("mid_rst_timeout", {31'b0, out_timeout}, 32'd0);
        chk("mid_rst_busy",    {28'b0, chan_busy},   32'd0);
        sb.delete();
        tick(3);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick(2);
        sb.push_back(mk(2, 250, 1'b0, 1'b0));
        passage(2, 1'b0, 250);
        drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/train_speed_tracker.md
# train_speed_tracker

- Multi-channel, direction-aware speed measurement for the crossing controller.
- Each crossing has two track sensors a fixed distance apart. The block times the interval between their rising edges per channel and converts it to speed with one shared sequential divider, arbitrated round-robin.
- It reports one record per passage, or per timeout, over a valid/ready stream to the crossing supervisor.

## Interface
Parameters:
- NUM_CROSSINGS, 4, number of independent channels (1..16)
- CNT_W, 24, width of the per-channel interval counter
- NUM_W, 32, width of the dividend constant and of the divider
- SPEED_W, 16, width of the reported speed
- DIST_CONST, 1000000, dividend: sensor spacing × speed scale, in counts·cycles
- TIMEOUT_CYC, 2**24-1, interval in cycles at which an open measurement is abandoned (≤ 2**CNT_W-1)

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sens_a  in  NUM_CROSSINGS  sensor A level per channel, pre-synchronised
- sens_b  in  NUM_CROSSINGS  sensor B level per channel, pre-synchronised
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_chan  out  $clog2(NUM_CROSSINGS) (min 1)  channel of record
- out_speed  out  SPEED_W  DIST_CONST/elapsed, saturated; 0 on timeout
- out_dir  out  1  0 = A→B, 1 = B→A
- out_timeout  out  1  record is a timeout
- chan_busy  out  NUM_CROSSINGS  channel not IDLE

## Operation
Edge detection:
- Sensors are registered per channel.
- Rising edge = current high and previous low.

Per-channel FSM states: IDLE, TIMING, PENDING.
- IDLE:
  - Edge on A only → TIMING, dir=0, counter=1.
  - Edge on B only → TIMING, dir=1, counter=1.
  - Edges on A and B in the same cycle → ignored, stay IDLE.
- TIMING:
  - Counter increments each cycle.
  - Edge on the closing sensor (B if dir=0, A if dir=1) → PENDING, elapsed=counter, timeout=0.
  - Repeat edges on the opening sensor are ignored.
  - If no close occurs and the counter reaches TIMEOUT_CYC → PENDING, timeout=1.
  - A close edge in the same cycle as the timeout: close wins.
- PENDING:
  - All sensor edges are ignored.
  - On arbiter grant → IDLE. Edges in the grant cycle are ignored.

Arbiter:
- Evaluated when the divider engine is IDLE.
- Grants the first PENDING channel at or after rr_ptr, scanning upward with wrap.
- rr_ptr ← granted+1 mod NUM_CROSSINGS.

Divider engine states: IDLE, DIV, DONE.
- Grant with timeout=0 → DIV: restoring division of DIST_CONST by elapsed, one quotient bit per cycle, NUM_W cycles.
- Grant with timeout=1 → DONE directly, speed=0.
- DONE: the record loads into the output register when out_valid=0, or when out_valid&&out_ready in that cycle. Otherwise the engine stalls in DONE.
- Quotient > 2**SPEED_W-1 → out_speed = 2**SPEED_W-1.
- Elapsed is always ≥1, so there is no divide-by-zero.

Output:
- out_valid holds, with all fields stable, until out_valid&&out_ready.

## Timing
- Reset values: out_valid=0, out_chan=0, out_speed=0, out_dir=0, out_timeout=0, chan_busy=0. All FSMs IDLE, rr_ptr=0, counters 0.
- Elapsed: opening edge sampled in cycle N and closing edge in cycle M → elapsed = M−N.
- Channel PENDING in cycle P → earliest grant in cycle P (engine idle).
- Division record: out_valid rises at G+NUM_W+1.
- Timeout record: out_valid rises at G+1.
- Throughput: one division per NUM_W+1 cycles. A channel may re-arm in the cycle after grant.
- Reset mid-operation: all in-flight measurements, divisions and undelivered records are discarded immediately.

## Structure
- Shared package railway_pkg holds:
  - chan_state_t {IDLE, TIMING, PENDING}
  - div_state_t {D_IDLE, D_DIV, D_DONE}
  - localparams DIR_AB=0 and DIR_BA=1
- Sub-module speed_divider: sequential restoring divider with start/done, parameterised by NUM_W, instantiated once.
- Channel FSMs live in a generate loop in the top.

## Test plan
- Single A→B: ch0 A edge at cycle 100, B edge at cycle 1100 → ch0 record, speed=1000, dir=0, timeout=0, out_valid at grant+33.
- B→A with SPEED_W=16: ch2 interval 10 cycles → speed=65535 (saturated), dir=1.
- Timeout with TIMEOUT_CYC=5000: ch1 A edge only → after 5000 cycles a record with timeout=1, speed=0; chan_busy[1] clears on grant.
- Contention: ch1 and ch3 close in the same cycle, rr_ptr=2 → ch3 reported first, then ch1.
- Backpressure: out_ready low for 200 cycles with 3 channels pending → one record held stable, engine stalls in DONE, no loss; all three delivered once ready returns.
- Reset mid-division: rst_n low during DIV → all outputs return to reset values the same cycle; a fresh passage afterwards measures correctly.
